vunpack: RTL and testbench



---
 rtl/vga_pkg.sv | 32 +++
 rtl/vunpack_if.sv | 12 +
 rtl/vdelay.sv | 29 ++
 rtl/vunpack.sv | 147 ++++++++++++++
 tb/tb_vunpack.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the framebuffer fetch / pixel unpack stage:
// pixel format, fetch FSM states and pack-to-pixel extraction.
package vga_pkg;

    localparam int PWIDTH    = 6;
    localparam int FIELD_W   = 2;
    localparam int RED_LSB   = 4;
    localparam int GREEN_LSB = 2;
    localparam int BLUE_LSB  = 0;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        WAIT
    } fetchStateT;

    // Pack is {byte2, byte1, byte0}; pixels are packed little-endian, 6 bits each.
    function automatic logic [PWIDTH-1:0] pixExtract(input logic [23:0] pack,
                                                     input logic [1:0]  idx);
        logic [PWIDTH-1:0] pix;
        case (idx)
            2'd0:    pix = pack[5:0];
            2'd1:    pix = pack[11:6];
            2'd2:    pix = pack[17:12];
            default: pix = pack[23:18];
        endcase
        return pix;
    endfunction

endpackage

// File: rtl/vunpack_if.sv
// Byte-wide synchronous framebuffer read port: the unpacker is the master,
// the RAM is the slave (data returns the cycle after the address is sampled).
interface vunpack_if #(
    parameter int AWIDTH = 16
);
    logic [AWIDTH-1:0] MemAddr;
    logic              MemRe;
    logic [7:0]        MemData;

    modport master (output MemAddr, MemRe, input MemData);
    modport slave  (input MemAddr, MemRe, output MemData);
endinterface

// File: rtl/vdelay.sv
// N-stage single-bit delay line with asynchronous active-high reset.
module vdelay #(
    parameter int N = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Din,
    output logic Dout
);

    logic [N-1:0] shiftQ;

    generate
        if (N > 1) begin : gMulti
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) shiftQ <= '0;
                else       shiftQ <= {shiftQ[N-2:0], Din};
            end
        end else begin : gSingle
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) shiftQ <= '0;
                else       shiftQ <= Din;
            end
        end
    endgenerate

    assign Dout = shiftQ[N-1];

endmodule

// File: rtl/vunpack.sv
// Framebuffer fetch and pixel unpack: reads a 3-byte pack per address strobe
// and serialises four 2:2:2 RGB pixels, blanked outside the active window.
//
// state | meaning
// IDLE  | no fetch in flight, accepts a strobe
// RD0   | byte 0 address on the bus
// RD1   | byte 1 address on the bus
// RD2   | byte 2 address on the bus, byte 0 captured
// WAIT  | byte 2 returning; pack loads on exit, accepts a strobe
module vunpack
    import vga_pkg::*;
#(
    parameter int AWIDTH   = 16,
    parameter int BLANKDLY = 4
) (
    input  logic              PixelClk,
    input  logic              Reset,
    input  logic [AWIDTH-1:0] AddrIn,
    input  logic              AddrStb,
    input  logic              IsActHorz,
    input  logic              IsActVert,
    vunpack_if.master         mem,
    output logic [1:0]        RedOut,
    output logic [1:0]        GreenOut,
    output logic [1:0]        BlueOut,
    output logic              Overrun
);

    fetchStateT        state, stateNext;
    logic [AWIDTH-1:0] reqAddr;
    logic [AWIDTH-1:0] memAddrQ, memAddrNext;
    logic              memReQ, memReNext;
    logic [7:0]        byte0, byte1;
    logic [23:0]       packQ;
    logic [1:0]        pixLeft;
    logic [PWIDTH-1:0] pixReg;
    logic              overrunQ;
    logic              accept, busy, loadPack, capB0, capB1;
    logic              actDly;

    assign accept = AddrStb && ((state == IDLE) || (state == WAIT));
    assign busy   = (state == RD0) || (state == RD1) || (state == RD2);

    always_ff @(posedge PixelClk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext   = state;
        memAddrNext = memAddrQ;
        memReNext   = memReQ;
        loadPack    = 1'b0;
        capB0       = 1'b0;
        capB1       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext   = RD0;
                    memAddrNext = AddrIn;
                    memReNext   = 1'b1;
                end
            end
            RD0: begin
                stateNext   = RD1;
                memAddrNext = reqAddr + AWIDTH'(1);
            end
            RD1: begin
                stateNext   = RD2;
                memAddrNext = reqAddr + AWIDTH'(2);
                capB0       = 1'b1;
            end
            RD2: begin
                stateNext = WAIT;
                memReNext = 1'b0;
                capB1     = 1'b1;
            end
            WAIT: begin
                loadPack = 1'b1;
                if (accept) begin
                    stateNext   = RD0;
                    memAddrNext = AddrIn;
                    memReNext   = 1'b1;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                memReNext = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PixelClk or posedge Reset) begin
        if (Reset) begin
            reqAddr  <= '0;
            memAddrQ <= '0;
            memReQ   <= 1'b0;
            byte0    <= '0;
            byte1    <= '0;
            overrunQ <= 1'b0;
        end else begin
            memAddrQ <= memAddrNext;
            memReQ   <= memReNext;
            if (accept) reqAddr <= AddrIn;
            if (capB0)  byte0   <= mem.MemData;
            if (capB1)  byte1   <= mem.MemData;
            if (AddrStb && busy) overrunQ <= 1'b1;
        end
    end

    // Byte 2 bypasses straight from the RAM so a strobe every 4 cycles leaves no pixel gap.
    always_ff @(posedge PixelClk or posedge Reset) begin
        if (Reset) begin
            packQ   <= '0;
            pixReg  <= '0;
            pixLeft <= '0;
        end else if (loadPack) begin
            packQ   <= {mem.MemData, byte1, byte0};
            pixReg  <= pixExtract({mem.MemData, byte1, byte0}, 2'd0);
            pixLeft <= 2'd3;
        end else if (pixLeft != 2'd0) begin
            pixReg  <= pixExtract(packQ, 2'd0 - pixLeft);
            pixLeft <= pixLeft - 2'd1;
        end else begin
            pixReg  <= '0;
        end
    end

    vdelay #(
        .N (BLANKDLY)
    ) uActDelay (
        .Clk   (PixelClk),
        .Reset (Reset),
        .Din   (IsActHorz & IsActVert),
        .Dout  (actDly)
    );

    assign mem.MemAddr = memAddrQ;
    assign mem.MemRe   = memReQ;
    assign Overrun     = overrunQ;
    assign RedOut      = actDly ? pixReg[RED_LSB   +: FIELD_W] : '0;
    assign GreenOut    = actDly ? pixReg[GREEN_LSB +: FIELD_W] : '0;
    assign BlueOut     = actDly ? pixReg[BLUE_LSB  +: FIELD_W] : '0;

endmodule

// File: tb/tb_vunpack.sv
// Self-checking bench for vunpack: behavioural framebuffer RAM, per-scenario tasks,
// and a cycle-tagged scoreboard of expected RGB values consumed on the falling edge.
module tb_vunpack;

    logic        PixelClk;
    logic        Reset;
    logic [15:0] AddrIn;
    logic        AddrStb;
    logic        IsActHorz;
    logic        IsActVert;
    logic [1:0]  RedOut, GreenOut, BlueOut;
    logic        Overrun;

    vunpack_if #(.AWIDTH(16)) mbus ();

    vunpack #(
        .AWIDTH   (16),
        .BLANKDLY (4)
    ) dut (
        .PixelClk  (PixelClk),
        .Reset     (Reset),
        .AddrIn    (AddrIn),
        .AddrStb   (AddrStb),
        .IsActHorz (IsActHorz),
        .IsActVert (IsActVert),
        .mem       (mbus.master),
        .RedOut    (RedOut),
        .GreenOut  (GreenOut),
        .BlueOut   (BlueOut),
        .Overrun   (Overrun)
    );

    logic [7:0] ram [0:65535];

    always @(posedge PixelClk)
        if (mbus.MemRe) mbus.MemData <= ram[mbus.MemAddr];

    initial begin
        PixelClk = 1'b0;
        forever #5 PixelClk = ~PixelClk;
    end

    int cyc = 0;
    always @(posedge PixelClk) cyc <= cyc + 1;

    int tests  = 0;
    int failed = 0;
    int lastStb;

    typedef struct {
        int         cyc;
        logic [5:0] pix;
    } expT;
    expT sb[$];
    expT e;

    always @(negedge PixelClk) begin
        if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            tests++;
            if (e.cyc != cyc) begin
                failed++;
                $display("FAIL sb_missed: expected pixel for cycle %0d, now cycle %0d", e.cyc, cyc);
            end else if ({RedOut, GreenOut, BlueOut} !== e.pix) begin
                failed++;
                $display("FAIL sb_rgb cycle %0d: got %h required %h", cyc,
                         {RedOut, GreenOut, BlueOut}, e.pix);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic strobe(input logic [15:0] a, input bit push, input bit actExp);
        logic [15:0] a1, a2;
        logic [7:0]  b0, b1, b2;
        logic [5:0]  p [4];
        int          s;
        @(negedge PixelClk);
        AddrIn  = a;
        AddrStb = 1'b1;
        @(posedge PixelClk);
        #1;
        AddrStb = 1'b0;
        s = cyc;
        lastStb = s;
        if (push) begin
            a1 = a + 16'd1;
            a2 = a + 16'd2;
            b0 = ram[a];
            b1 = ram[a1];
            b2 = ram[a2];
            p[0] = b0[5:0];
            p[1] = {b1[3:0], b0[7:6]};
            p[2] = {b2[1:0], b1[7:4]};
            p[3] = b2[7:2];
            for (int i = 0; i < 4; i++)
                sb.push_back('{cyc: s + 4 + i, pix: (actExp ? p[i] : 6'd0)});
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(posedge PixelClk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge PixelClk);
        #1;
        tests++;
        if (mbus.MemAddr !== 16'h0 || mbus.MemRe !== 1'b0) begin
            failed++;
            $display("FAIL reset_mem: got addr %h re %b required 0000 0", mbus.MemAddr, mbus.MemRe);
        end
        tests++;
        if ({RedOut, GreenOut, BlueOut, Overrun} !== 7'h0) begin
            failed++;
            $display("FAIL reset_out: got rgb %h ovr %b required 0 0",
                     {RedOut, GreenOut, BlueOut}, Overrun);
        end
        @(negedge PixelClk);
        Reset = 1'b0;
        repeat (5) @(posedge PixelClk);
    endtask

    task automatic test_single;
        int s;
        ram[16'h0100] = 8'h3F;
        ram[16'h0101] = 8'hC0;
        ram[16'h0102] = 8'hFF;
        strobe(16'h0100, 1'b1, 1'b1);
        s = lastStb;
        sb.insert(sb.size() - 4, '{cyc: s + 3, pix: 6'd0});
        sb.push_back('{cyc: s + 8, pix: 6'd0});
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (mbus.MemAddr !== 16'h0100 + 16'(k) || mbus.MemRe !== 1'b1) begin
                failed++;
                $display("FAIL single_addr%0d: got %h re %b required %h re 1", k,
                         mbus.MemAddr, mbus.MemRe, 16'h0100 + 16'(k));
            end
            @(posedge PixelClk);
            #1;
        end
        tests++;
        if (mbus.MemRe !== 1'b0) begin
            failed++;
            $display("FAIL single_re_off: got %b required 0", mbus.MemRe);
        end
        wait_until(s + 10);
    endtask

    task automatic test_back_to_back;
        int s;
        for (int i = 0; i < 9; i++) ram[i] = 8'h10 + 8'(i * 37);
        strobe(16'h0000, 1'b1, 1'b1);
        repeat (3) @(posedge PixelClk);
        strobe(16'h0003, 1'b1, 1'b1);
        repeat (3) @(posedge PixelClk);
        strobe(16'h0006, 1'b1, 1'b1);
        s = lastStb;
        sb.push_back('{cyc: s + 8, pix: 6'd0});
        wait_until(s + 10);
        tests++;
        if (Overrun !== 1'b0) begin
            failed++;
            $display("FAIL b2b_overrun: got %b required 0", Overrun);
        end
    endtask

    task automatic test_wrap;
        int s;
        logic [15:0] exp [3];
        exp[0] = 16'hFFFE;
        exp[1] = 16'hFFFF;
        exp[2] = 16'h0000;
        ram[16'hFFFE] = 8'h12;
        ram[16'hFFFF] = 8'h34;
        ram[16'h0000] = 8'h56;
        strobe(16'hFFFE, 1'b1, 1'b1);
        s = lastStb;
        sb.push_back('{cyc: s + 8, pix: 6'd0});
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (mbus.MemAddr !== exp[k]) begin
                failed++;
                $display("FAIL wrap_addr%0d: got %h required %h", k, mbus.MemAddr, exp[k]);
            end
            @(posedge PixelClk);
            #1;
        end
        wait_until(s + 10);
    endtask

    task automatic test_overrun;
        int s;
        ram[16'h0200] = 8'hA5;
        ram[16'h0201] = 8'h5A;
        ram[16'h0202] = 8'hC3;
        strobe(16'h0200, 1'b1, 1'b1);
        s = lastStb;
        sb.push_back('{cyc: s + 8, pix: 6'd0});
        tests++;
        if (Overrun !== 1'b0) begin
            failed++;
            $display("FAIL ovr_pre: got %b required 0", Overrun);
        end
        @(posedge PixelClk);
        strobe(16'h0300, 1'b0, 1'b1);
        tests++;
        if (Overrun !== 1'b1 || mbus.MemAddr !== 16'h0202) begin
            failed++;
            $display("FAIL ovr_set: got ovr %b addr %h required 1 0202", Overrun, mbus.MemAddr);
        end
        wait_until(s + 10);
        tests++;
        if (Overrun !== 1'b1 || mbus.MemRe !== 1'b0) begin
            failed++;
            $display("FAIL ovr_sticky: got ovr %b re %b required 1 0", Overrun, mbus.MemRe);
        end
    endtask

    task automatic test_blank;
        int s;
        ram[16'h0400] = 8'hFF;
        ram[16'h0401] = 8'hFF;
        ram[16'h0402] = 8'hFF;
        @(negedge PixelClk);
        IsActVert = 1'b0;
        repeat (5) @(posedge PixelClk);
        strobe(16'h0400, 1'b1, 1'b0);
        s = lastStb;
        sb.push_back('{cyc: s + 8, pix: 6'd0});
        wait_until(s + 10);
        @(negedge PixelClk);
        IsActVert = 1'b1;
        repeat (6) @(posedge PixelClk);
        strobe(16'h0400, 1'b0, 1'b1);
        @(posedge PixelClk);
        #1;
        IsActHorz = 1'b0;
        repeat (3) @(posedge PixelClk);
        #1;
        tests++;
        if ({RedOut, GreenOut, BlueOut} !== 6'h3F) begin
            failed++;
            $display("FAIL blank_before: got %h required 3f", {RedOut, GreenOut, BlueOut});
        end
        @(posedge PixelClk);
        #1;
        tests++;
        if ({RedOut, GreenOut, BlueOut} !== 6'h00) begin
            failed++;
            $display("FAIL blank_after: got %h required 00", {RedOut, GreenOut, BlueOut});
        end
        IsActHorz = 1'b1;
        repeat (8) @(posedge PixelClk);
    endtask

    task automatic test_reset_midfetch;
        int s;
        strobe(16'h0500, 1'b0, 1'b1);
        @(posedge PixelClk);
        #2;
        Reset = 1'b1;
        #1;
        tests++;
        if (mbus.MemAddr !== 16'h0 || mbus.MemRe !== 1'b0 || Overrun !== 1'b0) begin
            failed++;
            $display("FAIL rst_async: got addr %h re %b ovr %b required 0000 0 0",
                     mbus.MemAddr, mbus.MemRe, Overrun);
        end
        @(posedge PixelClk);
        @(negedge PixelClk);
        Reset = 1'b0;
        repeat (2) @(posedge PixelClk);
        ram[16'h0010] = 8'h21;
        ram[16'h0011] = 8'h43;
        ram[16'h0012] = 8'h65;
        strobe(16'h0010, 1'b1, 1'b1);
        s = lastStb;
        sb.push_back('{cyc: s + 8, pix: 6'd0});
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (mbus.MemAddr !== 16'h0010 + 16'(k)) begin
                failed++;
                $display("FAIL rst_refetch%0d: got %h required %h", k, mbus.MemAddr,
                         16'h0010 + 16'(k));
            end
            @(posedge PixelClk);
            #1;
        end
        wait_until(s + 10);
        tests++;
        if (Overrun !== 1'b0) begin
            failed++;
            $display("FAIL rst_overrun: got %b required 0", Overrun);
        end
    endtask

    initial begin
        Reset     = 1'b1;
        AddrIn    = '0;
        AddrStb   = 1'b0;
        IsActHorz = 1'b1;
        IsActVert = 1'b1;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;

        test_reset;
        test_single;
        test_back_to_back;
        test_wrap;
        test_overrun;
        test_blank;
        test_reset_midfetch;

        repeat (4) @(posedge PixelClk);
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
